fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised successor fetch stage: PC sequencer plus a decoupled instruction queue in front of decode.
- Issues reads to an external synchronous ROM (1-cycle read latency).
- Buffers returned instructions, tagged with their PC, in a QUEUE_DEPTH FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Supports relative or absolute branch redirect with flush, and halts cleanly at end of ROM.

Parameters:
ROM_SIZE, 512, instruction ROM depth in words
INSTR_WIDTH, 9, instruction word width
REG_WIDTH, 8, branch target/offset width
QUEUE_DEPTH, 4, instruction queue entries; power of two, >=2
REL_BRANCH, 1, 1: target is signed offset from branch_pc; 0: target is zero-extended absolute address
AW (derived, localparam), $clog2(ROM_SIZE)+1, PC/address width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: flush and begin fetching at start_addr
start_addr  input  AW  initial fetch address
branch  input  1  decode reports a branch instruction
taken  input  1  branch resolved taken (qualified by branch)
branch_pc  input  AW  PC of the branch instruction (REL_BRANCH=1)
target  input  REG_WIDTH  signed offset or absolute target
rom_en  output  1  ROM read request this cycle
rom_addr  output  AW  ROM read address
rom_data  input  INSTR_WIDTH  ROM data, valid the cycle after rom_en
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts head
instr_out  output  INSTR_WIDTH  head instruction
instr_pc  output  AW  head instruction PC
halted  output  1  HALT state, queue empty, no read in flight

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=0, queue count=0, in-flight flag=0.
  - All outputs 0: rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN on start.
  - RUN -> HALT when fetch_pc reaches >= ROM_SIZE, or when a redirect target is out of range.
  - HALT -> RUN on start or on an in-range redirect.
- Issue rule (RUN only): rom_en=1 iff count + inflight < QUEUE_DEPTH.
  - rom_addr=fetch_pc; fetch_pc increments on issue.
  - The queue can never overflow; no write is ever dropped.
- Response: the cycle after an issue, rom_data plus its PC is pushed, unless the read was killed.
- Dequeue:
  - instr_valid = count != 0; instr_out/instr_pc come from the head.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Start latency: start sampled at cycle N -> rom_en at N+1 -> push at N+2 -> instr_valid at N+3.
- Throughput: with instr_ready held high, steady state is 1 instruction per cycle.
- start (any state):
  - Flush the queue (count=0) and kill any in-flight read.
  - fetch_pc=start_addr; state=RUN if start_addr < ROM_SIZE, else HALT.
- Redirect (branch && taken, state RUN or HALT):
  - Flush the queue and kill any in-flight read.
  - New PC: REL_BRANCH=1 -> branch_pc + sign-extended target, computed at AW+1 bits signed. REL_BRANCH=0 -> zero-extended target.
  - Result in [0, ROM_SIZE-1] -> fetch_pc=result, state=RUN.
  - Otherwise state=HALT and fetch_pc is unchanged.
  - First rom_en for the new PC is the next cycle.
- branch && !taken: no effect.
- branch/taken in IDLE: ignored.
- Simultaneous events:
  - start beats redirect.
  - Redirect beats push: a killed response is dropped.
  - A handshake in the redirect cycle counts as consumed; all other entries are flushed.
- End of ROM: after issuing ROM_SIZE-1, fetch_pc=ROM_SIZE, state HALT.
  - The queue drains normally.
  - halted rises when count=0 and no read is in flight.
- Backpressure: instr_ready low stalls pops only. The queue fills to QUEUE_DEPTH, then rom_en deasserts.
- No wrap-around of fetch_pc to 0 in any case.
- Reset mid-operation clears everything asynchronously. A ROM response arriving after reset release is ignored.

Test Plan:
- Reset then start with start_addr=10, instr_ready=1 -> rom_en at N+1 with rom_addr=10; instr_valid at N+3 with instr_pc=10, then 11, 12, 13 on consecutive cycles.
- start_addr=0, instr_ready=0 for 10 cycles -> exactly 4 reads issued (addrs 0-3), count=4, rom_en=0. Raise ready -> PCs 0,1,2,3 then 4 with no gaps, nothing lost or duplicated.
- Running with REL_BRANCH=1, branch=taken=1, branch_pc=20, target=-5 -> queue flushed, next rom_addr=15, next valid instr_pc=15. Repeat with taken=0 -> stream continues unchanged.
- start_addr=508, ROM_SIZE=512 -> PCs 508-511 delivered, no rom_addr >= 512, halted=1 after last pop. Then start with start_addr=0 -> RUN resumes.
- branch_pc=2, target=-8 -> target out of range -> HALT, halted=1 once drained. start and a taken branch in the same cycle -> start_addr wins.
- Assert rst_n=0 mid-stream with a read in flight -> all outputs 0 immediately. After release, no instr_valid until a new start.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC sequencer issuing reads to a 1-cycle synchronous ROM, feeding a
// PC-tagged instruction FIFO that hands off to decode over valid/ready.
module fetch_queue_unit #(
    parameter int ROM_SIZE    = 512,
    parameter int INSTR_WIDTH = 9,
    parameter int REG_WIDTH   = 8,
    parameter int QUEUE_DEPTH = 4,
    parameter int REL_BRANCH  = 1,
    localparam int AW = $clog2(ROM_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          start_addr,
    input  logic                   branch,
    input  logic                   taken,
    input  logic [AW-1:0]          branch_pc,
    input  logic [REG_WIDTH-1:0]   target,
    output logic                   rom_en,
    output logic [AW-1:0]          rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [AW-1:0]          instr_pc,
    output logic                   halted
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int SW = AW + 1;
    localparam logic [AW-1:0] ROM_END = AW'(ROM_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [AW-1:0]          pc;
    } entry_t;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            infl_q, infl_d;
    logic [AW-1:0]   infl_pc_q, infl_pc_d;
    logic [QW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [QW:0]     cnt_q, cnt_d;
    entry_t          mem_q [QUEUE_DEPTH];

    logic            redirect, issue, push, pop, tgt_ok;
    logic [QW+1:0]   occ;
    logic signed [SW-1:0] tgt_calc;
    logic [AW-1:0]   pc_inc;

    // New PC is evaluated one bit wider than the PC so negative results are visible.
    generate
        if (REL_BRANCH != 0) begin : g_rel
            assign tgt_calc = $signed({1'b0, branch_pc}) + SW'($signed(target));
        end else begin : g_abs
            assign tgt_calc = $signed(SW'(target));
        end
    endgenerate

    assign tgt_ok   = !tgt_calc[SW-1] && (tgt_calc[AW-1:0] < ROM_END);
    assign redirect = branch && taken && (state_q != IDLE);
    assign occ      = {1'b0, cnt_q} + {{(QW+1){1'b0}}, infl_q};
    assign issue    = (state_q == RUN) && (occ < (QW+2)'(QUEUE_DEPTH)) && (pc_q < ROM_END);
    assign push     = infl_q && !start && !redirect;
    assign pop      = (cnt_q != '0) && instr_ready;
    assign pc_inc   = pc_q + AW'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_d    = infl_q;
        infl_pc_d = infl_pc_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        if (start) begin
            state_d = (start_addr < ROM_END) ? RUN : HALT;
            pc_d    = start_addr;
            infl_d  = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else if (redirect) begin
            // Out-of-range target halts but leaves the PC where it was.
            if (tgt_ok) begin
                state_d = RUN;
                pc_d    = tgt_calc[AW-1:0];
            end else begin
                state_d = HALT;
            end
            infl_d = 1'b0;
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
        end else begin
            infl_d = issue;
            if (issue) begin
                infl_pc_d = pc_q;
                pc_d      = pc_inc;
                if (pc_inc >= ROM_END) state_d = HALT;
            end else if (state_q == RUN && pc_q >= ROM_END) begin
                state_d = HALT;
            end
            if (push) wr_d = wr_q + QW'(1);
            if (pop)  rd_d = rd_q + QW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (QW+1)'(1);
                2'b01:   cnt_d = cnt_q - (QW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{instr: rom_data, pc: infl_pc_q};
    end

    assign rom_en      = issue;
    assign rom_addr    = issue ? pc_q : '0;
    assign instr_valid = (cnt_q != '0);
    assign instr_out   = instr_valid ? mem_q[rd_q].instr : '0;
    assign instr_pc    = instr_valid ? mem_q[rd_q].pc : '0;
    assign halted      = (state_q == HALT) && (cnt_q == '0) && !infl_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: start latency, backpressure, redirects, end of ROM, reset.
module tb_fetch_queue_unit;
    localparam int AW = 10;
    localparam int IW = 9;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          branch = 1'b0;
    logic          taken = 1'b0;
    logic [AW-1:0] branch_pc = '0;
    logic [RW-1:0] target = '0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          halted;

    int checks = 0;
    int errors = 0;

    fetch_queue_unit #(
        .ROM_SIZE(512), .INSTR_WIDTH(IW), .REG_WIDTH(RW), .QUEUE_DEPTH(4), .REL_BRANCH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .branch(branch), .taken(taken), .branch_pc(branch_pc), .target(target),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input int a);
        logic [AW-1:0] t;
        t = AW'(a) ^ 10'h155;
        return t[IW-1:0];
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_word(int'(rom_addr));

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%0d v=%b out=%0h pc=%0d h=%b exp all 0",
                     rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (rom_en !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got en=%b v=%b h=%b exp 0 0 0", rom_en, instr_valid, halted);
        end
    endtask

    task automatic test_start;
        start = 1'b1; start_addr = 10'd10; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 10'd10) begin
            errors++;
            $display("FAIL start_issue got en=%b addr=%0d exp en=1 addr=10", rom_en, rom_addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_early_valid got %b exp 0", instr_valid);
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'(10 + i) || instr_out !== rom_word(10 + i)) begin
                errors++;
                $display("FAIL start_stream[%0d] got v=%b pc=%0d data=%0h exp v=1 pc=%0d data=%0h",
                         i, instr_valid, instr_pc, instr_out, 10 + i, rom_word(10 + i));
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [AW-1:0] addrs[$];
        start = 1'b1; start_addr = '0; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rom_en) addrs.push_back(rom_addr);
            tick();
        end
        checks++;
        if (addrs.size() != 4) begin
            errors++;
            $display("FAIL bp_read_count got %0d exp 4", addrs.size());
        end
        for (int i = 0; i < addrs.size(); i++) begin
            checks++;
            if (addrs[i] !== 10'(i)) begin
                errors++;
                $display("FAIL bp_read_addr[%0d] got %0d exp %0d", i, addrs[i], i);
            end
        end
        checks++;
        if (rom_en !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full got en=%b v=%b exp en=0 v=1", rom_en, instr_valid);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'(i) || instr_out !== rom_word(i)) begin
                errors++;
                $display("FAIL bp_drain[%0d] got v=%b pc=%0d data=%0h exp v=1 pc=%0d data=%0h",
                         i, instr_valid, instr_pc, instr_out, i, rom_word(i));
            end
            tick();
        end
    endtask

    task automatic test_branch;
        branch = 1'b1; taken = 1'b1; branch_pc = 10'd20; target = 8'hFB;
        tick();
        branch = 1'b0; taken = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 10'd15) begin
            errors++;
            $display("FAIL br_redirect got v=%b en=%b addr=%0d exp v=0 en=1 addr=15",
                     instr_valid, rom_en, rom_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_flushed got v=%b exp 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'd15) begin
            errors++;
            $display("FAIL br_first got v=%b pc=%0d exp v=1 pc=15", instr_valid, instr_pc);
        end
        branch = 1'b1; taken = 1'b0;
        tick();
        branch = 1'b0;
        for (int i = 16; i < 19; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'(i)) begin
                errors++;
                $display("FAIL br_not_taken got v=%b pc=%0d exp v=1 pc=%0d", instr_valid, instr_pc, i);
            end
            tick();
        end
    endtask

    task automatic test_end_of_rom;
        int exp_pc;
        start = 1'b1; start_addr = 10'd508;
        tick();
        start = 1'b0;
        exp_pc = 508;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL eor_not_halted got %b exp 0", halted);
        end
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (rom_en === 1'b1 && rom_addr >= 10'd512) begin
                errors++;
                $display("FAIL eor_addr_bound got addr=%0d exp <512", rom_addr);
            end
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr_pc !== 10'(exp_pc)) begin
                    errors++;
                    $display("FAIL eor_pc got %0d exp %0d", instr_pc, exp_pc);
                end
                exp_pc++;
            end
            tick();
        end
        checks++;
        if (exp_pc != 512 || halted !== 1'b1 || instr_valid !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL eor_halt got next_pc=%0d h=%b v=%b en=%b exp 512 1 0 0",
                     exp_pc, halted, instr_valid, rom_en);
        end
        start = 1'b1; start_addr = '0;
        tick();
        start = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 10'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL eor_restart got en=%b addr=%0d h=%b exp 1 0 0", rom_en, rom_addr, halted);
        end
    endtask

    task automatic test_oob_branch;
        tick();
        branch = 1'b1; taken = 1'b1; branch_pc = 10'd2; target = 8'hF8;
        tick();
        branch = 1'b0; taken = 1'b0;
        checks++;
        if (halted !== 1'b1 || rom_en !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL oob_halt got h=%b en=%b v=%b exp 1 0 0", halted, rom_en, instr_valid);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL oob_stay got h=%b en=%b exp 1 0", halted, rom_en);
        end
        start = 1'b1; start_addr = 10'd100;
        branch = 1'b1; taken = 1'b1; branch_pc = 10'd20; target = 8'hFB;
        tick();
        start = 1'b0; branch = 1'b0; taken = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 10'd100) begin
            errors++;
            $display("FAIL start_beats_branch got en=%b addr=%0d exp en=1 addr=100", rom_en, rom_addr);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'd100) begin
            errors++;
            $display("FAIL start_beats_branch_pc got v=%b pc=%0d exp v=1 pc=100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid;
        checks++;
        if (rom_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_precond got en=%b exp 1", rom_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted} !== '0) begin
            errors++;
            $display("FAIL mid_reset got en=%b addr=%0d v=%b out=%0h pc=%0d h=%b exp all 0",
                     rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || rom_en !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d] got v=%b en=%b exp 0 0", c, instr_valid, rom_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_backpressure();
        test_branch();
        test_end_of_rom();
        test_oob_branch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
